gcc_track: RTL and testbench
============================

GCC_TRACK -- requirements
Module: gcc_track

Interface
REQ-001: Parameter TOL, default 2, per-axis tolerance in pixels (8-bit unsigned) for a sample to count as stable.
REQ-002: Parameter NLOCK, default 4, consecutive stable samples needed to lock (legal range 1..15).
REQ-003: Parameter NLOSE, default 2, consecutive out-of-tolerance samples needed to drop lock (legal range 1..15).
REQ-004: The block SHALL use one clock and an asynchronous, active-high reset; ports are named CLK and RESET.
REQ-005: CLK  in  1  rising-edge clock.
REQ-006: RESET  in  1  asynchronous active-high reset.
REQ-007: READY_  in  1  active-low sample-valid from the upstream centroid stage.
REQ-008: Xc  in  8  centroid X, unsigned.
REQ-009: Yc  in  8  centroid Y, unsigned.
REQ-010: CLR  in  1  synchronous clear.
REQ-011: LOCK  out  1  centroid locked.
REQ-012: Xl, Yl  out  8 each  locked reference centroid.
REQ-013: DX, DY  out  9 each  signed two's-complement delta, current sample minus previous sample.
REQ-014: EVT  out  1  one-cycle pulse on every lock or loss transition.
REQ-015: STAT  out  2  state: 00 IDLE, 01 ACQ, 10 LOCKED, 11 LOST.

Function
REQ-016: A sample is valid on a rising CLK edge where READY_=0; at edges with READY_=1, all state, counters and outputs SHALL hold, except EVT, which SHALL return to 0.
REQ-017: Deltas SHALL be formed as 9-bit signed values, {1'b0,Xc}-{1'b0,Xp}, with no wrap; |d|<=TOL is evaluated on the magnitude.
REQ-018: On each valid sample, Xp/Yp SHALL load Xc/Yc, and DX/DY SHALL register the delta against the old Xp/Yp; the first sample after IDLE SHALL give DX=DY=0.
REQ-019: IDLE: the first valid sample -> ACQ, with stab_cnt=0.
REQ-020: ACQ: on a valid sample with both |dx|,|dy|<=TOL versus Xp/Yp, stab_cnt increments; otherwise stab_cnt=0.
REQ-021: ACQ: the edge that registers the NLOCK-th consecutive stable sample SHALL -> LOCKED, set LOCK=1, set Xl/Yl=Xc/Yc, set EVT=1, and clear miss_cnt.
REQ-022: LOCKED: tolerance is checked against Xl/Yl, not Xp/Yp; out-of-tolerance increments miss_cnt, in-tolerance clears it.
REQ-023: LOCKED: the edge registering the NLOSE-th consecutive miss SHALL -> LOST, set LOCK=0, and set EVT=1; Xl/Yl hold their last value.
REQ-024: LOST: the next valid sample -> ACQ with stab_cnt=0; that sample loads Xp/Yp only.
REQ-025: EVT SHALL be high for exactly one cycle per transition and never on consecutive cycles.
REQ-026: With NLOCK=1, the first stable comparison in ACQ SHALL lock.
REQ-027: With NLOSE=1, a single miss SHALL drop lock.
REQ-028: CLR=1 at an edge SHALL force the reset state of REQ-030, regardless of READY_; CLR has priority over a valid sample.
REQ-029: Counters SHALL saturate and never wrap.

Reset
REQ-030: While RESET=1, asynchronously: STAT=00, LOCK=0, EVT=0, Xl=Yl=0, DX=DY=0, Xp=Yp=0, stab_cnt=miss_cnt=0.
REQ-031: Reset asserted mid-ACQ or mid-LOCKED SHALL discard all history; the first valid sample after release behaves as from IDLE.

Verification (TOL=2, NLOCK=4, NLOSE=2)
REQ-032: RESET pulse during LOCKED -> all outputs as in REQ-030 immediately, without waiting for CLK.
REQ-033: READY_=0, Xc/Yc held at 50/60 for 5 samples -> LOCK=1 after the 5th edge, Xl=50, Yl=60, STAT=10, EVT high for 1 cycle.
REQ-034: In ACQ, Xc sequence 50,52,50,51,50 -> all deltas are within tolerance and lock occurs on the 5th sample; with sequence 50,53,... the 53 clears stab_cnt and lock is delayed.
REQ-035: Locked at 50/60, Xc=55 for 1 sample then 50 -> LOCK stays 1 and no EVT; Xc=55 for 2 samples -> LOCK=0, STAT=11, EVT pulse, and the next valid sample gives STAT=01.
REQ-036: Xp=10, sample Xc=5 -> DX=9'h1FB (-5); Xp=0, Xc=255 -> DX=+255.
REQ-037: READY_=1 for 10 cycles mid-ACQ -> STAT, stab_cnt and DX unchanged; CLR=1 together with READY_=0 -> STAT=00, LOCK=0, and the sample is ignored.

Source files
------------

// File: rtl/gcc_track.sv
`default_nettype none
// ============================================================================
//  Module   : gcc_track
//  Purpose  : Centroid lock tracker. Watches a stream of (Xc,Yc) centroid
//             samples, reports sample-to-sample deltas, acquires lock after
//             NLOCK consecutive stable samples and drops it after NLOSE
//             consecutive samples outside tolerance of the locked reference.
//  Ports    : CLK     rising-edge clock
//             RESET   asynchronous active-high reset
//             READY_  active-low sample valid
//             Xc, Yc  8-bit unsigned centroid
//             CLR     synchronous clear (priority over a valid sample)
//             LOCK    locked flag
//             Xl, Yl  locked reference centroid
//             DX, DY  9-bit signed delta, current minus previous sample
//             EVT     one-cycle pulse on each lock / loss transition
//             STAT    00 IDLE, 01 ACQ, 10 LOCKED, 11 LOST
//  Revision : 1.0  initial release
// ============================================================================
module gcc_track #(
  parameter logic [7:0]  TOL   = 8'd2,
  parameter int unsigned NLOCK = 4,
  parameter int unsigned NLOSE = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READY_,
  input  logic [7:0] Xc,
  input  logic [7:0] Yc,
  input  logic       CLR,
  output logic       LOCK,
  output logic [7:0] Xl,
  output logic [7:0] Yl,
  output logic [8:0] DX,
  output logic [8:0] DY,
  output logic       EVT,
  output logic [1:0] STAT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACQ    = 2'b01,
    ST_LOCKED = 2'b10,
    ST_LOST   = 2'b11
  } state_t;

  localparam logic [3:0] NLOCK_C = 4'(NLOCK);
  localparam logic [3:0] NLOSE_C = 4'(NLOSE);
  localparam logic [8:0] TOL_C   = {1'b0, TOL};

  state_t     state_q, state_d;
  logic [7:0] xp_q, xp_d, yp_q, yp_d;
  logic [7:0] xl_q, xl_d, yl_q, yl_d;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;
  logic [3:0] stab_q, stab_d, miss_q, miss_d;
  logic       evt_q, evt_d;

  // 9-bit magnitude of a 9-bit signed difference of two 8-bit unsigned
  // values; the range is -255..+255 so the magnitude never overflows.
  function automatic logic [8:0] mag9(input logic [8:0] d);
    return d[8] ? (~d + 9'd1) : d;
  endfunction

  logic [8:0] dx_p, dy_p, dx_l, dy_l;
  logic       stable_p, stable_l;
  logic [3:0] stab_inc, miss_inc;

  // Deltas against the previous sample (reported) and against the lock
  // reference (used only for the in-lock tolerance test).
  assign dx_p = {1'b0, Xc} - {1'b0, xp_q};
  assign dy_p = {1'b0, Yc} - {1'b0, yp_q};
  assign dx_l = {1'b0, Xc} - {1'b0, xl_q};
  assign dy_l = {1'b0, Yc} - {1'b0, yl_q};

  assign stable_p = (mag9(dx_p) <= TOL_C) && (mag9(dy_p) <= TOL_C);
  assign stable_l = (mag9(dx_l) <= TOL_C) && (mag9(dy_l) <= TOL_C);

  // Saturating increments
  assign stab_inc = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
  assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

  always_comb begin
    state_d = state_q;
    xp_d    = xp_q;
    yp_d    = yp_q;
    xl_d    = xl_q;
    yl_d    = yl_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    stab_d  = stab_q;
    miss_d  = miss_q;
    evt_d   = 1'b0;

    if (CLR) begin
      state_d = ST_IDLE;
      xp_d    = '0;
      yp_d    = '0;
      xl_d    = '0;
      yl_d    = '0;
      dx_d    = '0;
      dy_d    = '0;
      stab_d  = '0;
      miss_d  = '0;
    end else if (!READY_) begin
      xp_d = Xc;
      yp_d = Yc;
      dx_d = dx_p;
      dy_d = dy_p;
      unique case (state_q)
        ST_IDLE: begin
          // No previous sample exists yet, so the delta is defined as zero.
          state_d = ST_ACQ;
          stab_d  = '0;
          dx_d    = '0;
          dy_d    = '0;
        end
        ST_ACQ: begin
          if (stable_p) begin
            stab_d = stab_inc;
            if (stab_inc >= NLOCK_C) begin
              state_d = ST_LOCKED;
              xl_d    = Xc;
              yl_d    = Yc;
              evt_d   = 1'b1;
              miss_d  = '0;
            end
          end else begin
            stab_d = '0;
          end
        end
        ST_LOCKED: begin
          if (stable_l) begin
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            // A loss right after the lock edge (only possible with NLOSE=1)
            // is deferred to the next miss so EVT never pulses back to back.
            if (miss_inc >= NLOSE_C && !evt_q) begin
              state_d = ST_LOST;
              evt_d   = 1'b1;
            end
          end
        end
        ST_LOST: begin
          state_d = ST_ACQ;
          stab_d  = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      xp_q    <= '0;
      yp_q    <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      stab_q  <= '0;
      miss_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xp_q    <= xp_d;
      yp_q    <= yp_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      stab_q  <= stab_d;
      miss_q  <= miss_d;
      evt_q   <= evt_d;
    end
  end

  assign STAT = state_q;
  assign LOCK = (state_q == ST_LOCKED);
  assign Xl   = xl_q;
  assign Yl   = yl_q;
  assign DX   = dx_q;
  assign DY   = dy_q;
  assign EVT  = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_gcc_track.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcc_track
//  Purpose  : Directed self-checking bench for gcc_track (TOL=2, NLOCK=4,
//             NLOSE=2). Each step queues the expected outputs, drives one
//             clock of stimulus, then pops and compares after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcc_track;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready_n = 1'b1;
  logic [7:0] xc = '0, yc = '0;
  logic       clr = 1'b0;
  logic       lock, evt;
  logic [7:0] xl, yl;
  logic [8:0] dx, dy;
  logic [1:0] stat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] stat;
    logic       lock;
    logic       evt;
    logic [7:0] xl;
    logic [7:0] yl;
    logic [8:0] dx;
    logic [8:0] dy;
  } exp_t;

  exp_t sb[$];

  gcc_track #(.TOL(8'd2), .NLOCK(4), .NLOSE(2)) dut (
    .CLK(clk), .RESET(rst), .READY_(ready_n), .Xc(xc), .Yc(yc), .CLR(clr),
    .LOCK(lock), .Xl(xl), .Yl(yl), .DX(dx), .DY(dy), .EVT(evt), .STAT(stat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    chk({tag, ".stat"}, {7'd0, stat}, {7'd0, e.stat});
    chk({tag, ".lock"}, {8'd0, lock}, {8'd0, e.lock});
    chk({tag, ".evt"},  {8'd0, evt},  {8'd0, e.evt});
    chk({tag, ".xl"},   {1'b0, xl},   {1'b0, e.xl});
    chk({tag, ".yl"},   {1'b0, yl},   {1'b0, e.yl});
    chk({tag, ".dx"},   dx,           e.dx);
    chk({tag, ".dy"},   dy,           e.dy);
  endtask

  // One clock step: queue expectation, drive inputs, compare after the edge.
  task automatic step(input string tag, input logic rn, input logic c,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [1:0] e_stat, input logic e_lock, input logic e_evt,
                      input logic [7:0] e_xl, input logic [7:0] e_yl,
                      input logic [8:0] e_dx, input logic [8:0] e_dy);
    exp_t e;
    e = '{stat: e_stat, lock: e_lock, evt: e_evt, xl: e_xl, yl: e_yl, dx: e_dx, dy: e_dy};
    @(negedge clk);
    ready_n = rn;
    clr     = c;
    xc      = x;
    yc      = y;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s observed empty-scoreboard expected entry", tag);
    end else begin
      compare_all(tag, sb.pop_front());
    end
  endtask

  localparam exp_t ZERO = '0;

  initial begin
    // Reset state, checked while reset is held
    #3;
    compare_all("reset", ZERO);
    @(negedge clk);
    rst = 1'b0;

    // Constant 50/60: acquire on sample 1, lock on sample 5
    step("hold1", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("hold2", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("hold3", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("hold4", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("hold5", 0, 0, 50, 60, 2'b10, 1, 1, 50, 60, 9'h000, 9'h000);
    step("evt_off", 1, 0, 99, 99, 2'b10, 1, 0, 50, 60, 9'h000, 9'h000);

    // Single miss then recovery keeps lock; two misses lose it
    step("miss1", 0, 0, 55, 60, 2'b10, 1, 0, 50, 60, 9'h005, 9'h000);
    step("recover", 0, 0, 50, 60, 2'b10, 1, 0, 50, 60, 9'h1FB, 9'h000);
    step("missA", 0, 0, 55, 60, 2'b10, 1, 0, 50, 60, 9'h005, 9'h000);
    step("missB", 0, 0, 55, 60, 2'b11, 0, 1, 50, 60, 9'h000, 9'h000);
    step("lost_acq", 0, 0, 55, 60, 2'b01, 0, 0, 50, 60, 9'h000, 9'h000);

    // CLR with a valid sample: sample ignored, everything cleared
    step("clr_valid", 0, 1, 99, 99, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);

    // Jitter within tolerance still locks on the 5th sample
    step("jit1", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jit2", 0, 0, 52, 60, 2'b01, 0, 0, 0, 0, 9'h002, 9'h000);
    step("jit3", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h1FE, 9'h000);
    step("jit4", 0, 0, 51, 60, 2'b01, 0, 0, 0, 0, 9'h001, 9'h000);
    step("jit5", 0, 0, 50, 60, 2'b10, 1, 1, 50, 60, 9'h1FF, 9'h000);

    // A jump of 3 restarts stability, delaying lock to the 6th sample
    step("clr_idle", 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jmp1", 0, 0, 50, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jmp2", 0, 0, 53, 60, 2'b01, 0, 0, 0, 0, 9'h003, 9'h000);
    step("jmp3", 0, 0, 53, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jmp4", 0, 0, 53, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jmp5", 0, 0, 53, 60, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("jmp6", 0, 0, 53, 60, 2'b10, 1, 1, 53, 60, 9'h000, 9'h000);

    // Delta sign and range extremes
    step("clr_d1", 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    step("d10", 0, 0, 10, 0, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("d5", 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 9'h1FB, 9'h000);
    step("clr_d2", 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 9'h000, 9'h000);
    step("dmin", 0, 0, 0, 255, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("dmax", 0, 0, 255, 0, 2'b01, 0, 0, 0, 0, 9'h0FF, 9'h101);

    // Stall mid-ACQ: state, delta and stability count must all hold
    step("stab1", 0, 0, 254, 0, 2'b01, 0, 0, 0, 0, 9'h1FF, 9'h000);
    for (int i = 0; i < 10; i++)
      step("stall", 1, 0, 8'(i * 37), 8'(i * 11), 2'b01, 0, 0, 0, 0, 9'h1FF, 9'h000);
    step("stab2", 0, 0, 254, 0, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("stab3", 0, 0, 254, 0, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);
    step("stab4", 0, 0, 254, 0, 2'b10, 1, 1, 254, 0, 9'h000, 9'h000);

    // Asynchronous reset while locked, observed between clock edges
    @(negedge clk);
    ready_n = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    compare_all("async_rst", ZERO);
    #1;
    rst = 1'b0;

    // History discarded: first sample behaves as from IDLE (delta zero)
    step("post_rst", 0, 0, 7, 7, 2'b01, 0, 0, 0, 0, 9'h000, 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
